// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants and state encoding for the fetch controller
package fetch_ctrl_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_ctrl_adder.sv
// rtl/fetch_ctrl_adder.sv - modulo 2^N adder
module fetch_ctrl_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_ctrl_reg.sv
// rtl/fetch_ctrl_reg.sv - enabled register with synchronous reset value
module fetch_ctrl_reg #(
    parameter int         N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC, memory request, IF/ID hand-off
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int           N        = INSTR_W,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    output logic         mem_req,
    output logic [N-1:0] mem_addr,
    input  logic         mem_ready,
    input  logic [N-1:0] mem_rdata,
    output logic         instr_valid,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] pc_out,
    output logic         flush,
    output logic [31:0]  fetch_count
);

    state_t       state_q, state_d;
    logic         pending_q, pending_d;
    logic [N-1:0] redirect_q, redirect_d;
    logic         valid_q, valid_d;
    logic [N-1:0] instr_q, instr_d;
    logic [N-1:0] pc_out_q, pc_out_d;
    logic [31:0]  count_q, count_d;

    logic         pc_en;
    logic [N-1:0] pc_d, pc_q, pc_plus4;

    fetch_ctrl_reg #(.N(N), .RESET_VAL(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en_i (pc_en),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    fetch_ctrl_adder #(.N(N)) u_pc_inc (
        .a_i   (pc_q),
        .b_i   (N'(PC_STEP)),
        .sum_o (pc_plus4)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        redirect_d = redirect_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        count_d    = count_q;
        pc_en      = 1'b0;
        pc_d       = pc_plus4;
        mem_req    = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // A redirect seen during the fetch discards its data; a fresh branch beats the stored one
                    if (branch_taken || pending_q) begin
                        pc_en     = 1'b1;
                        pc_d      = branch_taken ? branch_addr : redirect_q;
                        pending_d = 1'b0;
                    end else begin
                        pc_en    = 1'b1;
                        instr_d  = mem_rdata;
                        pc_out_d = pc_plus4;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if (branch_taken) begin
                    pending_d  = 1'b1;
                    redirect_d = branch_addr;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    pc_en   = 1'b1;
                    pc_d    = branch_addr;
                    state_d = S_REQ;
                end else if (!freeze) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            redirect_q <= '0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_out_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            redirect_q <= redirect_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            count_q    <= count_d;
        end
    end

    assign mem_addr    = pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;
    assign flush       = branch_taken && (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector table plus randomized run against a behavioural model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, mem_ready;
    logic [31:0] branch_addr, mem_rdata;
    logic        mem_req, instr_valid, flush;
    logic [31:0] mem_addr, instr_out, pc_out, fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .flush        (flush),
        .fetch_count  (fetch_count)
    );

    typedef struct {
        logic        rst, frz, br;
        logic [31:0] baddr;
        logic        rdy;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pcout;
        logic        fl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                       input logic rd, input logic [31:0] rdat, input logic rq, input logic [31:0] ad,
                       input logic v, input logic [31:0] ins, input logic [31:0] pco,
                       input logic fl, input logic [31:0] c);
        vec_t e;
        e.rst = r; e.frz = f; e.br = b; e.baddr = ba; e.rdy = rd; e.rdata = rdat;
        e.req = rq; e.addr = ad; e.valid = v; e.instr = ins; e.pcout = pco; e.fl = fl; e.cnt = c;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input int cyc, input logic rq, input logic [31:0] ad, input logic v,
                             input logic [31:0] ins, input logic [31:0] pco, input logic fl,
                             input logic [31:0] c);
        check("mem_req", cyc, {31'd0, mem_req}, {31'd0, rq});
        check("mem_addr", cyc, mem_addr, ad);
        check("instr_valid", cyc, {31'd0, instr_valid}, {31'd0, v});
        check("instr_out", cyc, instr_out, ins);
        check("pc_out", cyc, pc_out, pco);
        check("flush", cyc, {31'd0, flush}, {31'd0, fl});
        check("fetch_count", cyc, fetch_count, c);
    endtask

    // Behavioural model: a fetch is either outstanding or an instruction is parked for IF/ID
    bit          m_started, m_have;
    logic [31:0] m_pc, m_instr, m_pcout, m_count;
    logic [31:0] m_redir[$];

    task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] ba,
                              input logic rd, input logic [31:0] rdat);
        if (r) begin
            m_started = 0; m_have = 0; m_pc = 0; m_instr = 0; m_pcout = 0; m_count = 0;
            m_redir.delete();
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_have) begin
            if (b) begin
                m_have = 0; m_pc = ba;
            end else if (!f) begin
                m_have = 0; m_count = m_count + 1;
            end
        end else if (rd) begin
            if (b) m_pc = ba;
            else if (m_redir.size() != 0) m_pc = m_redir[0];
            else begin
                m_have = 1; m_instr = rdat; m_pcout = m_pc + 4; m_pc = m_pc + 4;
            end
            m_redir.delete();
        end else if (b) begin
            m_redir.delete();
            m_redir.push_back(ba);
        end
    endtask

    initial begin
        int mem_cnt, mem_lat;
        bit exp_req;

        rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0; mem_ready = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1 check_all(-1, 0, 0, 0, 0, 0, 0, 0);

        // rst frz br baddr rdy rdata | req addr valid instr pcout flush cnt
        add(0,0,0,0,0,0,                 0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 1,0,0,0,0,0,0);
        add(0,0,0,0,1,32'hA000_0000,     1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 0,4,1,32'hA000_0000,4,0,0);
        add(0,0,0,0,0,0,                 1,4,0,32'hA000_0000,4,0,1);
        add(0,0,0,0,1,32'hA000_0001,     1,4,0,32'hA000_0000,4,0,1);
        add(0,0,0,0,0,0,                 0,8,1,32'hA000_0001,8,0,1);
        add(0,0,0,0,0,0,                 1,8,0,32'hA000_0001,8,0,2);
        add(0,0,0,0,1,32'hA000_0002,     1,8,0,32'hA000_0001,8,0,2);
        add(0,1,0,0,0,0,                 0,12,1,32'hA000_0002,12,0,2);
        add(0,1,0,0,1,32'hDEAD_BEEF,     0,12,1,32'hA000_0002,12,0,2);
        add(0,1,0,0,0,0,                 0,12,1,32'hA000_0002,12,0,2);
        add(0,1,0,0,0,0,                 0,12,1,32'hA000_0002,12,0,2);
        add(0,0,0,0,0,0,                 0,12,1,32'hA000_0002,12,0,2);
        add(0,0,0,0,0,0,                 1,12,0,32'hA000_0002,12,0,3);
        add(0,0,0,0,1,32'hA000_0003,     1,12,0,32'hA000_0002,12,0,3);
        add(0,1,1,32'h100,0,0,           0,16,1,32'hA000_0003,16,1,3);
        add(0,0,0,0,0,0,                 1,32'h100,0,32'hA000_0003,16,0,3);
        add(0,0,0,0,1,32'hB000_0000,     1,32'h100,0,32'hA000_0003,16,0,3);
        add(0,0,0,0,0,0,                 0,32'h104,1,32'hB000_0000,32'h104,0,3);
        add(0,0,1,32'h10,0,0,            1,32'h104,0,32'hB000_0000,32'h104,1,4);
        add(0,0,0,0,1,32'hBAD0_0001,     1,32'h104,0,32'hB000_0000,32'h104,0,4);
        add(0,0,0,0,0,0,                 1,32'h10,0,32'hB000_0000,32'h104,0,4);
        add(0,0,1,32'h200,0,0,           1,32'h10,0,32'hB000_0000,32'h104,1,4);
        add(0,0,0,0,0,0,                 1,32'h10,0,32'hB000_0000,32'h104,0,4);
        add(0,0,0,0,1,32'hBAD0_0002,     1,32'h10,0,32'hB000_0000,32'h104,0,4);
        add(0,0,0,0,0,0,                 1,32'h200,0,32'hB000_0000,32'h104,0,4);
        add(0,0,1,32'h280,0,0,           1,32'h200,0,32'hB000_0000,32'h104,1,4);
        add(0,0,1,32'h300,1,32'hBAD0_0003, 1,32'h200,0,32'hB000_0000,32'h104,1,4);
        add(0,0,0,0,0,0,                 1,32'h300,0,32'hB000_0000,32'h104,0,4);
        add(0,0,1,32'h400,0,0,           1,32'h300,0,32'hB000_0000,32'h104,1,4);
        add(1,0,0,0,0,0,                 1,32'h300,0,32'hB000_0000,32'h104,0,4);
        add(0,0,1,32'h700,1,32'hBAD0_0004, 0,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 1,0,0,0,0,0,0);
        add(0,0,0,0,1,32'hC000_0000,     1,0,0,0,0,0,0);
        add(0,0,0,0,0,0,                 0,4,1,32'hC000_0000,4,0,0);
        add(0,0,1,32'hFFFF_FFFC,0,0,     1,4,0,32'hC000_0000,4,1,1);
        add(0,0,0,0,1,32'hBAD0_0005,     1,4,0,32'hC000_0000,4,0,1);
        add(0,0,0,0,0,0,                 1,32'hFFFF_FFFC,0,32'hC000_0000,4,0,1);
        add(0,0,0,0,1,32'hE000_0000,     1,32'hFFFF_FFFC,0,32'hC000_0000,4,0,1);
        add(0,0,0,0,0,0,                 0,0,1,32'hE000_0000,0,0,1);
        add(0,0,0,0,0,0,                 1,0,0,32'hE000_0000,0,0,2);

        rst = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; freeze = vecs[i].frz; branch_taken = vecs[i].br;
            branch_addr = vecs[i].baddr; mem_ready = vecs[i].rdy; mem_rdata = vecs[i].rdata;
            #1 check_all(i, vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].instr,
                         vecs[i].pcout, vecs[i].fl, vecs[i].cnt);
            @(negedge clk);
        end

        // Randomized run: memory with per-request latency 1..3, stray mem_ready outside fetches
        rst = 1; freeze = 0; branch_taken = 0; mem_ready = 0;
        model_step(1, 0, 0, 0, 0, 0);
        mem_cnt = 0; mem_lat = 1;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            freeze       = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            branch_addr  = $urandom & 32'hFFFF_FFFC;
            mem_rdata    = $urandom;
            exp_req      = m_started && !m_have;
            if (exp_req) begin
                if (mem_cnt == mem_lat) begin
                    mem_ready = 1; mem_cnt = 0; mem_lat = $urandom_range(1, 3);
                end else begin
                    mem_ready = 0; mem_cnt++;
                end
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_cnt = 0;
            end
            if (rst) mem_cnt = 0;
            #1 check_all(1000 + c, exp_req, m_pc, m_have, m_instr, m_pcout,
                         m_started && branch_taken, m_count);
            model_step(rst, freeze, branch_taken, branch_addr, mem_ready, mem_rdata);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
